mem_port_arbiter: RTL and testbench

//  Shares the single multi-cycle stallmem port between the CPU instruction-fetch and data-access requesters.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arb_timer.sv | 38 +++
 rtl/mem_port_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the stallmem port arbiter: FSM states, owner encoding and timer width.
package mem_arb_pkg;

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    function automatic owner_e other_owner(input owner_e o);
        return (o == OWN_D) ? OWN_I : OWN_D;
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Wait-cycle counter for the arbiter: cleared on issue, counts while waiting,
// flags the cycle in which the MAX_WAIT-th wait cycle is reached.
module mem_arb_timer
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en && !expired) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // count_q holds the number of wait cycles already completed
    assign expired = en && (count_q == CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single stallmem port between instruction fetch and data access.
// Define MEM_ARB_RR_EN for round-robin on contested grants; default is data-first priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_ready,
    input  logic              mem_err,
    output logic              busy
);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
`ifdef MEM_ARB_RR_EN
    owner_e            rr_q, rr_d;
`endif

    logic              i_ack_q, i_ack_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic              i_err_q, i_err_d;
    logic              d_ack_q, d_ack_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              d_err_q, d_err_d;
    logic              mem_en_q, mem_en_d;
    logic              busy_q, busy_d;

    owner_e            win_c;
    logic              tmr_clear_c;
    logic              tmr_en_c;
    logic              tmr_expired_c;
    logic              done_c;
    logic              timeout_c;
    logic [DATA_W-1:0] rdata_c;
    logic              err_c;

    mem_arb_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clear_c),
        .en      (tmr_en_c),
        .expired (tmr_expired_c)
    );

    // Next-state, request latch and grant selection
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wr_d        = wr_q;
`ifdef MEM_ARB_RR_EN
        rr_d        = rr_q;
`endif
        win_c       = OWN_D;
        tmr_clear_c = 1'b0;
        tmr_en_c    = 1'b0;
        done_c      = 1'b0;
        timeout_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
`ifdef MEM_ARB_RR_EN
                    if (i_req && d_req) begin
                        win_c = rr_q;
                        rr_d  = other_owner(rr_q);
                    end else begin
                        win_c = d_req ? OWN_D : OWN_I;
                    end
`else
                    win_c = d_req ? OWN_D : OWN_I;
`endif
                    owner_d = win_c;
                    addr_d  = (win_c == OWN_D) ? d_addr : i_addr;
                    wdata_d = (win_c == OWN_D) ? d_wdata : '0;
                    wr_d    = (win_c == OWN_D) && d_wr;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                tmr_clear_c = 1'b1;
                if (mem_ready) begin
                    done_c  = 1'b1;
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                tmr_en_c = 1'b1;
                // ready on the limit cycle is a normal completion
                if (mem_ready) begin
                    done_c  = 1'b1;
                    state_d = RESP;
                end else if (tmr_expired_c) begin
                    timeout_c = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered responses: data and error only accompany the owner's ack
    always_comb begin
        rdata_c   = done_c ? mem_data_out : '0;
        err_c     = timeout_c || (done_c && mem_err);

        i_ack_d   = (done_c || timeout_c) && (owner_q == OWN_I);
        i_rdata_d = i_ack_d ? rdata_c : '0;
        i_err_d   = i_ack_d && err_c;

        d_ack_d   = (done_c || timeout_c) && (owner_q == OWN_D);
        d_rdata_d = (d_ack_d && !wr_q) ? rdata_c : '0;
        d_err_d   = d_ack_d && err_c;

        mem_en_d  = (state_d == ISSUE);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_I;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_q      <= 1'b0;
`ifdef MEM_ARB_RR_EN
            rr_q      <= OWN_D;
`endif
            i_ack_q   <= 1'b0;
            i_rdata_q <= '0;
            i_err_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            d_rdata_q <= '0;
            d_err_q   <= 1'b0;
            mem_en_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wr_q      <= wr_d;
`ifdef MEM_ARB_RR_EN
            rr_q      <= rr_d;
`endif
            i_ack_q   <= i_ack_d;
            i_rdata_q <= i_rdata_d;
            i_err_q   <= i_err_d;
            d_ack_q   <= d_ack_d;
            d_rdata_q <= d_rdata_d;
            d_err_q   <= d_err_d;
            mem_en_q  <= mem_en_d;
            busy_q    <= busy_d;
        end
    end

    assign i_ack       = i_ack_q;
    assign i_rdata     = i_rdata_q;
    assign i_err       = i_err_q;
    assign d_ack       = d_ack_q;
    assign d_rdata     = d_rdata_q;
    assign d_err       = d_err_q;
    assign mem_en      = mem_en_q;
    assign mem_wr      = wr_q;
    assign mem_addr    = addr_q;
    assign mem_data_in = wdata_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, reset and arbitration sequences,
// then randomized rounds against a transaction-level model with a latency-scripted memory.
module tb_mem_port_arbiter;

    localparam int MW = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req = 1'b0;
    logic        d_wr = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_en;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out = '0;
    logic        mem_ready = 1'b0;
    logic        mem_err = 1'b0;
    logic        busy;

    mem_port_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MAX_WAIT (MW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_ack        (i_ack),
        .i_rdata      (i_rdata),
        .i_err        (i_err),
        .d_req        (d_req),
        .d_wr         (d_wr),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_ack        (d_ack),
        .d_rdata      (d_rdata),
        .d_err        (d_err),
        .mem_en       (mem_en),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .mem_ready    (mem_ready),
        .mem_err      (mem_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nerr = 0;
    int nchk = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rdflt(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    // Stallmem model: each mem_en pops a scripted latency (-1 = never ready) and error flag
    logic [31:0] mem_arr [logic [31:0]];
    int          lat_q [$];
    bit          err_q [$];
    bit          pend = 1'b0;
    int          pcnt = 0;
    int          plat = -1;
    bit          perr = 1'b0;
    bit          pwr = 1'b0;
    logic [31:0] paddr = '0;

    always @(negedge clk) begin
        if (!rst) begin
            pend      = 1'b0;
            mem_ready = 1'b0;
            mem_err   = 1'b0;
        end else begin
            if (mem_en) begin
                pend  = 1'b1;
                pcnt  = 0;
                paddr = mem_addr;
                pwr   = mem_wr;
                if (lat_q.size() > 0) begin
                    plat = lat_q.pop_front();
                    perr = err_q.pop_front();
                end else begin
                    plat = -1;
                    perr = 1'b0;
                end
                if (mem_wr) mem_arr[mem_addr] = mem_data_in;
            end else if (pend) begin
                pcnt++;
            end
            if (pend && plat >= 0 && pcnt == plat) begin
                mem_ready    = 1'b1;
                mem_err      = perr;
                mem_data_out = pwr ? $urandom : (mem_arr.exists(paddr) ? mem_arr[paddr] : rdflt(paddr));
                pend         = 1'b0;
            end else begin
                mem_ready    = 1'b0;
                mem_err      = 1'($urandom_range(0, 1));
                mem_data_out = $urandom;
            end
        end
    end

    // Reference model state: shadow memory and round-robin preference
    logic [31:0] shadow [logic [31:0]];
`ifdef MEM_ARB_RR_EN
    bit rr_ptr = 1'b1;
`endif

    function automatic logic [31:0] sh_rd(input logic [31:0] a);
        return shadow.exists(a) ? shadow[a] : rdflt(a);
    endfunction

    // Owner (1 = data) of a grant; contested grants follow the arbitration rule
    function automatic bit pick(input bit contested, input bit dreq);
        bit o;
        if (!contested) return dreq;
`ifdef MEM_ARB_RR_EN
        o      = rr_ptr;
        rr_ptr = ~o;
`else
        o = 1'b1;
`endif
        return o;
    endfunction

    typedef struct {
        bit          ri, rd, dwr;
        logic [31:0] ia, da, wd;
        int          lat_i, lat_d;
        bit          e_i, e_d;
        bit          x_d;
        logic [31:0] x_rd;
        bit          x_err;
    } vec_t;

    function automatic vec_t mk(bit ri, bit rd, bit dwr, logic [31:0] ia, logic [31:0] da,
                                logic [31:0] wd, int li, int ld, bit ei, bit ed,
                                bit xd, logic [31:0] xrd, bit xe);
        vec_t v;
        v.ri = ri; v.rd = rd; v.dwr = dwr; v.ia = ia; v.da = da; v.wd = wd;
        v.lat_i = li; v.lat_d = ld; v.e_i = ei; v.e_d = ed;
        v.x_d = xd; v.x_rd = xrd; v.x_err = xe;
        return v;
    endfunction

    // Waits for one ack while checking the issue pulse, the held request and quiet response outputs
    task automatic wait_ack(input logic [31:0] ea, input logic [31:0] ewd, input bit ewr,
                            input bit own_d, input bit scramble,
                            output bit got, output bit who, output logic [31:0] rd,
                            output bit er, output int at);
        bit issued = 1'b0;
        got = 1'b0; who = 1'b0; rd = '0; er = 1'b0; at = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (mem_en) begin
                chk("single_mem_en", 128'(issued), 128'(0));
                issued = 1'b1;
                chk("mem_addr", 128'(mem_addr), 128'(ea));
                chk("mem_wr", 128'(mem_wr), 128'(ewr));
                if (ewr) chk("mem_data_in", 128'(mem_data_in), 128'(ewd));
                if (scramble) begin
                    if (own_d) begin
                        d_addr  = $urandom;
                        d_wdata = $urandom;
                        d_wr    = 1'($urandom_range(0, 1));
                    end else begin
                        i_addr = $urandom;
                    end
                end
            end else if (issued && !i_ack && !d_ack) begin
                chk("held_request", 128'({mem_wr, mem_addr, ewr ? mem_data_in : 32'h0}),
                    128'({ewr, ea, ewd}));
            end
            if (i_ack || d_ack) begin
                got = 1'b1;
                who = d_ack;
                rd  = d_ack ? d_rdata : i_rdata;
                er  = d_ack ? d_err : i_err;
                at  = cyc;
                chk("single_ack", 128'(i_ack & d_ack), 128'(0));
                chk("other_resp_zero", 128'(d_ack ? {i_rdata, i_err} : {d_rdata, d_err}), 128'(0));
                return;
            end
            chk("resp_zero_without_ack", 128'({i_rdata, d_rdata, i_err, d_err}), 128'(0));
        end
        chk("ack_within_budget", 128'(0), 128'(1));
    endtask

    // One request round; the winner drops its request on its ack, a loser stays pending
    task automatic run_round(input vec_t v, output bit f_d, output logic [31:0] f_rd, output bit f_err);
        bit          ord [2];
        int          n;
        int          lat_e [2];
        logic [31:0] ea [2], ewd [2], erd [2];
        bit          ewr [2], eer [2];
        bit          got, who, er;
        logic [31:0] rd;
        int          at, c;
        f_d = 1'b0; f_rd = '0; f_err = 1'b0;
        if (v.ri && v.rd) begin
            ord[0] = pick(1'b1, 1'b1);
            ord[1] = ~ord[0];
            n = 2;
        end else begin
            ord[0] = v.rd;
            ord[1] = 1'b0;
            n = 1;
        end
        for (int k = 0; k < n; k++) begin
            int l;
            bit e;
            l      = ord[k] ? v.lat_d : v.lat_i;
            e      = ord[k] ? v.e_d : v.e_i;
            ea[k]  = ord[k] ? v.da : v.ia;
            ewr[k] = ord[k] && v.dwr;
            ewd[k] = ewr[k] ? v.wd : 32'h0;
            if (ewr[k]) begin
                shadow[v.da] = v.wd;
                erd[k] = '0;
            end else begin
                erd[k] = (l < 0) ? 32'h0 : sh_rd(ea[k]);
            end
            eer[k]   = (l < 0) || e;
            lat_e[k] = (l < 0) ? MW : l;
            lat_q.push_back(l);
            err_q.push_back(e);
        end
        i_req = v.ri; i_addr = v.ia;
        d_req = v.rd; d_wr = v.dwr; d_addr = v.da; d_wdata = v.wd;
        c = cyc;
        for (int k = 0; k < n; k++) begin
            wait_ack(ea[k], ewd[k], ewr[k], ord[k], 1'b1, got, who, rd, er, at);
            if (!got) begin
                i_req = 1'b0;
                d_req = 1'b0;
                break;
            end
            chk("ack_owner", 128'(who), 128'(ord[k]));
            chk("ack_rdata", 128'(rd), 128'(erd[k]));
            chk("ack_err", 128'(er), 128'(eer[k]));
            chk("ack_cycle", 128'(at), 128'(c + lat_e[k] + 2));
            if (k == 0) begin
                f_d = who; f_rd = rd; f_err = er;
            end
            if (ord[k]) d_req = 1'b0; else i_req = 1'b0;
            c = at + 1;
        end
        @(negedge clk);
        chk("busy_back_to_idle", 128'(busy), 128'(0));
        chk("no_extra_ack", 128'({i_ack, d_ack}), 128'(0));
        lat_q.delete();
        err_q.delete();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [10];
        vec_t        v;
        bit          fd, fe, got, who, er;
        logic [31:0] frd, rd;
        int          at, ni, nd, seen;
        bit          exp_o [6];

        vecs[0] = mk(1, 0, 0, 32'h40,  32'h0,   32'h0,        4,  0, 0, 0, 0, rdflt(32'h40), 0);
        vecs[1] = mk(0, 1, 1, 32'h0,   32'h100, 32'hDEADBEEF, 0,  2, 0, 0, 1, 32'h0, 0);
        vecs[2] = mk(0, 1, 0, 32'h0,   32'h100, 32'h0,        0,  1, 0, 0, 1, 32'hDEADBEEF, 0);
        vecs[3] = mk(1, 1, 0, 32'h200, 32'h300, 32'h0,        0,  3, 0, 0, 1, rdflt(32'h300), 0);
        vecs[4] = mk(1, 0, 0, 32'h44,  32'h0,   32'h0,        -1, 0, 0, 0, 0, 32'h0, 1);
        vecs[5] = mk(0, 1, 0, 32'h0,   32'h100, 32'h0,        0,  8, 0, 0, 1, 32'hDEADBEEF, 0);
        vecs[6] = mk(1, 0, 0, 32'h48,  32'h0,   32'h0,        3,  0, 1, 0, 0, rdflt(32'h48), 1);
        vecs[7] = mk(0, 1, 1, 32'h0,   32'h104, 32'h1234,     0, -1, 0, 0, 1, 32'h0, 1);
`ifdef MEM_ARB_RR_EN
        vecs[8] = mk(1, 1, 1, 32'h50,  32'h54,  32'hCAFEF00D, 2,  2, 0, 0, 0, rdflt(32'h50), 0);
`else
        vecs[8] = mk(1, 1, 1, 32'h50,  32'h54,  32'hCAFEF00D, 2,  2, 0, 0, 1, 32'h0, 0);
`endif
        vecs[9] = mk(0, 1, 0, 32'h0,   32'h104, 32'h0,        0,  0, 0, 0, 1, 32'h1234, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 128'({i_ack, i_err, d_ack, d_err, mem_en, mem_wr, busy,
                                   i_rdata, d_rdata, mem_addr}), 128'(0));
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 10; k++) begin
            run_round(vecs[k], fd, frd, fe);
            chk("vec_first_owner", 128'(fd), 128'(vecs[k].x_d));
            chk("vec_first_rdata", 128'(frd), 128'(vecs[k].x_rd));
            chk("vec_first_err", 128'(fe), 128'(vecs[k].x_err));
        end

        // Reset asserted while an access is stalled in WAIT
        lat_q.push_back(-1);
        err_q.push_back(1'b0);
        i_req = 1'b1; i_addr = 32'h60;
        seen = 0;
        for (int t = 0; t < 10 && seen == 0; t++) begin
            @(negedge clk);
            if (mem_en) seen = 1;
        end
        chk("reset_test_issued", 128'(seen), 128'(1));
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_reset_outputs", 128'({i_ack, i_err, d_ack, d_err, mem_en, mem_wr, busy,
                                         i_rdata, d_rdata, mem_addr, mem_data_in}), 128'(0));
        i_req = 1'b0;
        lat_q.delete();
        err_q.delete();
`ifdef MEM_ARB_RR_EN
        rr_ptr = 1'b1;
`endif
        @(posedge clk);
        #2 rst = 1'b1;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            chk("no_ack_after_reset", 128'({i_ack, d_ack, busy}), 128'(0));
        end
        v = mk(1, 0, 0, 32'h60, 32'h0, 32'h0, 2, 0, 0, 0, 0, rdflt(32'h60), 0);
        run_round(v, fd, frd, fe);
        chk("post_reset_rdata", 128'(frd), 128'(rdflt(32'h60)));

        // Both requesters held for three accesses each
        ni = 3; nd = 3;
        for (int g = 0; g < 6; g++) begin
            exp_o[g] = pick(ni > 0 && nd > 0, nd > 0);
            if (exp_o[g]) nd--; else ni--;
            lat_q.push_back(1);
            err_q.push_back(1'b0);
        end
        ni = 3; nd = 3;
        i_req = 1'b1; i_addr = 32'h80;
        d_req = 1'b1; d_addr = 32'h84; d_wr = 1'b0; d_wdata = 32'h0;
        for (int g = 0; g < 6; g++) begin
            wait_ack(exp_o[g] ? 32'h84 : 32'h80, 32'h0, 1'b0, exp_o[g], 1'b0, got, who, rd, er, at);
            if (!got) break;
            chk("grant_order", 128'(who), 128'(exp_o[g]));
            chk("grant_rdata", 128'(rd), 128'(sh_rd(exp_o[g] ? 32'h84 : 32'h80)));
            if (exp_o[g]) begin
                nd--;
                if (nd == 0) d_req = 1'b0;
            end else begin
                ni--;
                if (ni == 0) i_req = 1'b0;
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
        chk("held_seq_idle", 128'(busy), 128'(0));
        lat_q.delete();
        err_q.delete();

        // Randomized rounds over a small shared address window
        for (int r = 0; r < 40; r++) begin
            v.ri    = 1'($urandom_range(0, 1));
            v.rd    = 1'($urandom_range(0, 1));
            if (!v.ri && !v.rd) v.rd = 1'b1;
            v.dwr   = 1'($urandom_range(0, 1));
            v.ia    = 32'h400 + 32'(4 * $urandom_range(0, 7));
            v.da    = 32'h400 + 32'(4 * $urandom_range(0, 7));
            v.wd    = $urandom;
            v.lat_i = ($urandom_range(0, 9) == 9) ? -1 : int'($urandom_range(0, 8));
            v.lat_d = ($urandom_range(0, 9) == 9) ? -1 : int'($urandom_range(0, 8));
            v.e_i   = ($urandom_range(0, 7) == 0);
            v.e_d   = ($urandom_range(0, 7) == 0);
            v.x_d   = 1'b0; v.x_rd = '0; v.x_err = 1'b0;
            run_round(v, fd, frd, fe);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
